// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and the pipeline NOP encoding
package fetch_unit_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int INST_W_DEF = 8;

    // Decode and the hazard unit insert this same encoding for bubbles.
    localparam logic [INST_W_DEF-1:0] NOP_INST = 8'h00;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID output register with a one-entry skid buffer
import fetch_unit_pkg::*;

module if_id_reg #(
    parameter int                 PC_W   = PC_W_DEF,
    parameter int                 INST_W = INST_W_DEF,
    parameter logic [INST_W-1:0]  NOP    = NOP_INST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              skid_push,
    input  logic              skid_pop,
    input  logic              flush,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc_calc,
    output logic              inst_valid
);

    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic              skid_valid;

    // Flush wins over everything so a redirect also throws away a parked instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            inst       <= NOP;
            pc_calc    <= '0;
            inst_valid <= 1'b0;
            skid_inst  <= NOP;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            inst       <= NOP;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_pop) begin
            inst       <= skid_inst;
            pc_calc    <= skid_pc;
            inst_valid <= 1'b1;
            skid_valid <= 1'b0;
        end else if (load) begin
            inst       <= in_inst;
            pc_calc    <= in_pc;
            inst_valid <= 1'b1;
        end else if (skid_push) begin
            skid_inst  <= in_inst;
            skid_pc    <= in_pc;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, imem handshake and IF/ID feed
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP      = NOP_INST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc_calc,
    output logic              inst_valid
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] drop_addr;
    logic [PC_W-1:0] pc_inc;
    logic            xfer;
    logic            load;
    logic            skid_push;
    logic            skid_pop;
    logic            flush;

    assign pc_inc    = pc + PC_ONE;
    assign imem_req  = !reset && (state != S_HOLD);
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;
    assign xfer      = imem_req && imem_ack;

    // A missed fetch with decode ready becomes a bubble, so it shares the flush path.
    assign flush     = redirect_valid || (state == S_REQ && !xfer && !stall);
    assign load      = !redirect_valid && state == S_REQ && xfer && !stall;
    assign skid_push = !redirect_valid && state == S_REQ && xfer && stall;
    assign skid_pop  = !redirect_valid && state == S_HOLD && !stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                S_REQ: begin
                    // An unacked request cannot be retracted; remember it so its data is eaten.
                    if (!xfer) begin
                        drop_addr <= pc;
                        state     <= S_DROP;
                    end
                end
                S_HOLD:  state <= S_REQ;
                S_DROP:  if (xfer) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (xfer) begin
                        pc <= pc_inc;
                        if (stall) state <= S_HOLD;
                    end
                end
                S_HOLD:  if (!stall) state <= S_REQ;
                S_DROP:  if (xfer) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .NOP    (NOP)
    ) u_if_id_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .skid_push  (skid_push),
        .skid_pop   (skid_pop),
        .flush      (flush),
        .in_inst    (imem_data),
        .in_pc      (pc_inc),
        .inst       (inst),
        .pc_calc    (pc_calc),
        .inst_valid (inst_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed fetch scenarios
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data;
    logic [7:0] inst;
    logic [7:0] pc_calc;
    logic       inst_valid;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic        stall_q = 1'b0;
    logic        reset_q = 1'b1;

    always #5 clock = ~clock;

    assign imem_data = imem_addr ^ 8'hA5;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .inst           (inst),
        .pc_calc        (pc_calc),
        .inst_valid     (inst_valid)
    );

    always @(posedge clock) begin
        stall_q <= stall;
        reset_q <= reset;
    end

    // Without a stall on the last edge, a valid IF/ID value is a freshly delivered instruction.
    always @(negedge clock) begin
        if (!reset_q && !stall_q && inst_valid) begin
            logic [15:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_inst got inst=%h pc_calc=%h expected none", inst, pc_calc);
            end else begin
                e = exp_q.pop_front();
                if (inst !== e[15:8] || pc_calc !== e[7:0]) begin
                    bad++;
                    $display("FAIL sb_inst got inst=%h pc_calc=%h expected inst=%h pc_calc=%h",
                             inst, pc_calc, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic r, input logic [7:0] rpc);
        stall          = s;
        imem_ack       = a;
        redirect_valid = r;
        redirect_pc    = rpc;
        @(posedge clock);
        #2;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic fetch_ok(input logic [7:0] addr);
        logic [7:0] nxt;
        nxt = addr + 8'h01;
        chk("fetch_addr", {24'h0, imem_addr}, {24'h0, addr});
        exp_q.push_back({addr ^ 8'hA5, nxt});
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({name, "_inst"}, {24'h0, inst}, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk_bubble("rst");
        chk("rst_pc_calc", {24'h0, pc_calc}, 32'h0);
        reset = 1'b0;
        #1;
        chk("first_req", {31'h0, imem_req}, 32'h1);

        // zero-wait streaming from RESET_PC
        for (int a = 0; a < 5; a++) fetch_ok(8'(a));

        // two wait states on address 05
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_bubble("wait1");
        chk("wait1_addr", {24'h0, imem_addr}, 32'h05);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_bubble("wait2");
        chk("wait2_addr", {24'h0, imem_addr}, 32'h05);
        for (int a = 5; a < 16; a++) fetch_ok(8'(a));

        // stall while the ack for 10 arrives
        chk("stall_addr", {24'h0, imem_addr}, 32'h10);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_inst", {24'h0, inst}, 32'hAA);
        chk("hold_pc_calc", {24'h0, pc_calc}, 32'h10);
        chk("hold_valid", {31'h0, inst_valid}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("hold3_inst", {24'h0, inst}, 32'hAA);
        exp_q.push_back({8'hB5, 8'h11});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_skid_addr", {24'h0, imem_addr}, 32'h11);
        chk("post_skid_req", {31'h0, imem_req}, 32'h1);
        for (int a = 17; a < 34; a++) fetch_ok(8'(a));

        // redirect to 40 while 22 is outstanding
        chk("pend_addr", {24'h0, imem_addr}, 32'h22);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        chk_bubble("redir");
        chk("drop_addr1", {24'h0, imem_addr}, 32'h22);
        chk("drop_req", {31'h0, imem_req}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drop_addr2", {24'h0, imem_addr}, 32'h22);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk_bubble("dropped");
        fetch_ok(8'h40);

        // redirect plus stall with a full skid buffer
        step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("skid_full_req", {31'h0, imem_req}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 8'h80);
        chk_bubble("skid_flush");
        chk("skid_flush_addr", {24'h0, imem_addr}, 32'h80);
        fetch_ok(8'h80);

        // wrap at FF, then reset during an outstanding request
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        fetch_ok(8'hFF);
        chk("wrap_addr", {24'h0, imem_addr}, 32'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_bubble("mid_rst");
        chk("mid_rst_pc_calc", {24'h0, pc_calc}, 32'h0);
        reset = 1'b0;
        #1;
        fetch_ok(8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("sb_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
